// File: rtl/inst_encoder.sv
// inst_encoder: packs RV32I fields into an instruction word and streams it
// to the instruction-memory write port at sequential word addresses.
// Optional INST_ENC_RANGE_CHECK_EN: drop requests whose immediate does not fit.
module inst_encoder #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rd_addr,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic [31:0]       imm,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [31:0]       wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       word_cnt,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LP_STEP = ADDR_W'(4);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [2:0] {
    F_R, F_I, F_H, F_S, F_B, F_J, F_U
  } fmt_e;

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  fmt_e        w_fmt;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_illegal;
  logic [31:0] w_inst;
  logic        w_range_ok;
  logic        w_accept;
  logic        w_load;
  logic        w_drop;
  logic        w_drain;
  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0] r_word_cnt;
  logic        r_err;
  logic [7:0]  r_err_cnt;

  // Decode op_sel into instruction format, opcode and function fields
  always_comb begin
    w_fmt     = F_R;
    w_opc     = 7'd0;
    w_f3      = 3'd0;
    w_f7      = 7'd0;
    w_illegal = 1'b0;
    case (op_sel)
      5'd0:  begin w_fmt = F_I; w_opc = OPC_LOAD;  w_f3 = 3'd2; end
      5'd1:  begin w_fmt = F_S; w_opc = OPC_STORE; w_f3 = 3'd2; end
      5'd2:  begin w_fmt = F_R; w_opc = OPC_OP;    w_f3 = 3'd0; end
      5'd3:  begin w_fmt = F_I; w_opc = OPC_OPIMM; w_f3 = 3'd0; end
      5'd4:  begin w_fmt = F_R; w_opc = OPC_OP;    w_f3 = 3'd0; w_f7 = F7_ALT; end
      5'd5:  begin w_fmt = F_R; w_opc = OPC_OP;    w_f3 = 3'd7; end
      5'd6:  begin w_fmt = F_R; w_opc = OPC_OP;    w_f3 = 3'd6; end
      5'd7:  begin w_fmt = F_R; w_opc = OPC_OP;    w_f3 = 3'd4; end
      5'd8:  begin w_fmt = F_I; w_opc = OPC_OPIMM; w_f3 = 3'd7; end
      5'd9:  begin w_fmt = F_I; w_opc = OPC_OPIMM; w_f3 = 3'd6; end
      5'd10: begin w_fmt = F_I; w_opc = OPC_OPIMM; w_f3 = 3'd4; end
      5'd11: begin w_fmt = F_R; w_opc = OPC_OP;    w_f3 = 3'd1; end
      5'd12: begin w_fmt = F_R; w_opc = OPC_OP;    w_f3 = 3'd5; end
      5'd13: begin w_fmt = F_R; w_opc = OPC_OP;    w_f3 = 3'd5; w_f7 = F7_ALT; end
      5'd14: begin w_fmt = F_H; w_opc = OPC_OPIMM; w_f3 = 3'd1; end
      5'd15: begin w_fmt = F_H; w_opc = OPC_OPIMM; w_f3 = 3'd5; end
      5'd16: begin w_fmt = F_H; w_opc = OPC_OPIMM; w_f3 = 3'd5; w_f7 = F7_ALT; end
      5'd17: begin w_fmt = F_R; w_opc = OPC_OP;    w_f3 = 3'd2; end
      5'd18: begin w_fmt = F_R; w_opc = OPC_OP;    w_f3 = 3'd3; end
      5'd19: begin w_fmt = F_I; w_opc = OPC_OPIMM; w_f3 = 3'd2; end
      5'd20: begin w_fmt = F_I; w_opc = OPC_OPIMM; w_f3 = 3'd3; end
      5'd21: begin w_fmt = F_B; w_opc = OPC_BR;    w_f3 = 3'd0; end
      5'd22: begin w_fmt = F_B; w_opc = OPC_BR;    w_f3 = 3'd1; end
      5'd23: begin w_fmt = F_B; w_opc = OPC_BR;    w_f3 = 3'd4; end
      5'd24: begin w_fmt = F_B; w_opc = OPC_BR;    w_f3 = 3'd5; end
      5'd25: begin w_fmt = F_B; w_opc = OPC_BR;    w_f3 = 3'd6; end
      5'd26: begin w_fmt = F_B; w_opc = OPC_BR;    w_f3 = 3'd7; end
      5'd27: begin w_fmt = F_J; w_opc = OPC_JAL; end
      5'd28: begin w_fmt = F_I; w_opc = OPC_JALR;  w_f3 = 3'd0; end
      5'd29: begin w_fmt = F_U; w_opc = OPC_LUI; end
      5'd30: begin w_fmt = F_U; w_opc = OPC_AUIPC; end
      default: w_illegal = 1'b1;
    endcase
  end

  // Scatter the immediate and register fields into the instruction word
  always_comb begin
    w_inst = 32'd0;
    case (w_fmt)
      F_R: w_inst = {w_f7, rs2_addr, rs1_addr, w_f3, rd_addr, w_opc};
      F_I: w_inst = {imm[11:0], rs1_addr, w_f3, rd_addr, w_opc};
      F_H: w_inst = {w_f7, imm[4:0], rs1_addr, w_f3, rd_addr, w_opc};
      F_S: w_inst = {imm[11:5], rs2_addr, rs1_addr, w_f3,
                     imm[4:0], w_opc};
      F_B: w_inst = {imm[12], imm[10:5], rs2_addr, rs1_addr, w_f3,
                     imm[4:1], imm[11], w_opc};
      F_J: w_inst = {imm[20], imm[10:1], imm[11], imm[19:12],
                     rd_addr, w_opc};
      F_U: w_inst = {imm[31:12], rd_addr, w_opc};
      default: w_inst = 32'd0;
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  // Immediate must be representable in the chosen format
  always_comb begin
    w_range_ok = 1'b1;
    case (w_fmt)
      F_I, F_S: w_range_ok = (&imm[31:11]) | ~(|imm[31:11]);
      F_B: w_range_ok = !imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
      F_J: w_range_ok = !imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
      F_U: w_range_ok = ~(|imm[11:0]);
      F_H: w_range_ok = ~(|imm[31:5]);
      default: w_range_ok = 1'b1;
    endcase
  end
`else
  logic w_unused_imm0;
  assign w_unused_imm0 = imm[0];
  assign w_range_ok    = 1'b1;
`endif

  assign w_accept = in_valid & in_ready;
  assign w_drain  = wr_valid & wr_ready;
  assign w_load   = w_accept & !clear & !w_illegal & w_range_ok;
  assign w_drop   = w_accept & !clear & (w_illegal | !w_range_ok);

  // Output-stage state register; clear empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_state <= ST_EMPTY;
    else if (clear) r_state <= ST_EMPTY;
    else            r_state <= w_state_nxt;
  end

  // Next state: fill on load, empty on drain without a refill
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_drain && !w_load) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake outputs derived from the stage state
  always_comb begin
    wr_valid = (r_state == ST_FULL);
    in_ready = !wr_valid || wr_ready;
  end

  // Held instruction word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_data <= 32'd0;
    else if (clear)  r_data <= 32'd0;
    else if (w_load) r_data <= w_inst;
  end

  // Word address and write counter advance on every write handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= LP_BASE;
      r_word_cnt <= 16'd0;
    end else if (clear) begin
      r_addr     <= LP_BASE;
      r_word_cnt <= 16'd0;
    end else if (w_drain) begin
      r_addr     <= r_addr + LP_STEP;
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  // Sticky error flag and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (clear) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (w_drop) begin
      r_err     <= 1'b1;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign wr_data  = r_data;
  assign wr_addr  = r_addr;
  assign word_cnt = r_word_cnt;
  assign err      = r_err;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench for inst_encoder, randomized requests
// against an arithmetic reference encoder, plus directed corner cases.
module tb_inst_encoder;

  localparam int AW   = 4;
  localparam int BASE = 8;

  logic          clk = 1'b0;
  logic          rst, clear, in_valid, in_ready, wr_valid, wr_ready, err;
  logic [4:0]    op_sel, rd_addr, rs1_addr, rs2_addr;
  logic [31:0]   imm, wr_data;
  logic [AW-1:0] wr_addr;
  logic [15:0]   word_cnt;
  logic [7:0]    err_cnt;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd_addr(rd_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm(imm),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_addr(wr_addr),
    .word_cnt(word_cnt), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  bit [31:0]   q[$];
  int          exp_addr = BASE;
  int          exp_cnt  = 0;
  int          exp_err  = 0;
  bit          mon_en   = 1'b0;
  bit          rnd_ready = 1'b0;

  task automatic chk(input string name, input bit [31:0] act,
                     input bit [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Reference: format and field constants per operation
  function automatic void lookup(input int op, output byte fmt,
                                 output int opc, output int f3,
                                 output int f7);
    fmt = "X"; opc = 0; f3 = 0; f7 = 0;
    case (op)
      0:  begin fmt = "I"; opc = 'h03; f3 = 2; end
      1:  begin fmt = "S"; opc = 'h23; f3 = 2; end
      2:  begin fmt = "R"; opc = 'h33; f3 = 0; end
      3:  begin fmt = "I"; opc = 'h13; f3 = 0; end
      4:  begin fmt = "R"; opc = 'h33; f3 = 0; f7 = 'h20; end
      5:  begin fmt = "R"; opc = 'h33; f3 = 7; end
      6:  begin fmt = "R"; opc = 'h33; f3 = 6; end
      7:  begin fmt = "R"; opc = 'h33; f3 = 4; end
      8:  begin fmt = "I"; opc = 'h13; f3 = 7; end
      9:  begin fmt = "I"; opc = 'h13; f3 = 6; end
      10: begin fmt = "I"; opc = 'h13; f3 = 4; end
      11: begin fmt = "R"; opc = 'h33; f3 = 1; end
      12: begin fmt = "R"; opc = 'h33; f3 = 5; end
      13: begin fmt = "R"; opc = 'h33; f3 = 5; f7 = 'h20; end
      14: begin fmt = "H"; opc = 'h13; f3 = 1; end
      15: begin fmt = "H"; opc = 'h13; f3 = 5; end
      16: begin fmt = "H"; opc = 'h13; f3 = 5; f7 = 'h20; end
      17: begin fmt = "R"; opc = 'h33; f3 = 2; end
      18: begin fmt = "R"; opc = 'h33; f3 = 3; end
      19: begin fmt = "I"; opc = 'h13; f3 = 2; end
      20: begin fmt = "I"; opc = 'h13; f3 = 3; end
      21: begin fmt = "B"; opc = 'h63; f3 = 0; end
      22: begin fmt = "B"; opc = 'h63; f3 = 1; end
      23: begin fmt = "B"; opc = 'h63; f3 = 4; end
      24: begin fmt = "B"; opc = 'h63; f3 = 5; end
      25: begin fmt = "B"; opc = 'h63; f3 = 6; end
      26: begin fmt = "B"; opc = 'h63; f3 = 7; end
      27: begin fmt = "J"; opc = 'h6F; end
      28: begin fmt = "I"; opc = 'h67; f3 = 0; end
      29: begin fmt = "U"; opc = 'h37; end
      30: begin fmt = "U"; opc = 'h17; end
      default: fmt = "X";
    endcase
  endfunction

  // Reference: returns 1 when the request should be written
  function automatic bit ref_enc(input int op, input int rd, input int r1,
                                 input int r2, input bit [31:0] im,
                                 output bit [31:0] w);
    byte fmt; int opc, f3, f7;
    bit [31:0] b;
    bit ok;
    longint s;
    lookup(op, fmt, opc, f3, f7);
    s  = longint'($signed(im));
    ok = (fmt != "X");
    b  = 32'(r1 << 15) | 32'(f3 << 12) | 32'(opc);
    case (fmt)
      "R": w = b | 32'(f7 << 25) | 32'(r2 << 20) | 32'(rd << 7);
      "I": w = b | ((im & 32'hFFF) << 20) | 32'(rd << 7);
      "H": w = b | 32'(f7 << 25) | ((im & 32'h1F) << 20) | 32'(rd << 7);
      "S": w = b | (((im >> 5) & 32'h7F) << 25) | 32'(r2 << 20)
               | ((im & 32'h1F) << 7);
      "B": w = b | (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25)
               | 32'(r2 << 20) | (((im >> 1) & 32'hF) << 8)
               | (((im >> 11) & 1) << 7);
      "J": w = 32'(opc) | 32'(rd << 7) | (((im >> 20) & 1) << 31)
               | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 1) << 20)
               | (((im >> 12) & 32'hFF) << 12);
      "U": w = (im & 32'hFFFFF000) | 32'(rd << 7) | 32'(opc);
      default: w = 32'd0;
    endcase
`ifdef INST_ENC_RANGE_CHECK_EN
    case (fmt)
      "I", "S": ok = (s >= -2048) && (s <= 2047);
      "B": ok = (im % 2 == 0) && (s >= -4096) && (s <= 4094);
      "J": ok = (im % 2 == 0) && (s >= -(64'sd1 << 20))
                && (s <= (64'sd1 << 20) - 2);
      "U": ok = (im % 4096 == 0);
      "H": ok = (im < 32);
      default: ;
    endcase
`else
    if (s == 0) ok = ok;
`endif
    return ok;
  endfunction

  // Drive one request; push the expected word on acceptance
  task automatic send(input int op, input int rd, input int r1,
                      input int r2, input bit [31:0] im,
                      input bit push, input bit [31:0] ex);
    bit acc = 1'b0;
    int n = 0;
    op_sel = op[4:0]; rd_addr = rd[4:0];
    rs1_addr = r1[4:0]; rs2_addr = r2[4:0]; imm = im;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept want accept");
    end else if (push) q.push_back(ex);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_model(input int op, input int rd, input int r1,
                            input int r2, input bit [31:0] im);
    bit [31:0] w;
    bit ok;
    ok = ref_enc(op, rd, r1, r2, im, w);
    if (!ok) exp_err++;
    send(op, rd, r1, r2, im, ok, w);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(posedge clk); n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every presented word must match the scoreboard head
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
      if (wr_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_write: got %h want none", wr_data);
        end else begin
          chk("wr_data", wr_data, q[0]);
          chk("wr_addr", 32'(wr_addr), 32'(exp_addr));
          if (wr_ready) begin
            void'(q.pop_front());
            exp_addr = (exp_addr + 4) % (1 << AW);
            exp_cnt++;
          end
        end
      end
    end
  end

  // Random consumer backpressure when enabled
  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) wr_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), BASE);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    bit [31:0] held_d;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    op_sel = '0; rd_addr = '0; rs1_addr = '0; rs2_addr = '0; imm = '0;
    #1 check_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    wr_ready = 1'b1;

    send(3, 1, 0, 0, 32'd5, 1, 32'h00500093);
    send(29, 2, 0, 0, 32'h12345000, 1, 32'h12345137);
    send(21, 0, 1, 2, 32'hFFFFFFFC, 1, 32'hFE208EE3);
    send(1, 0, 1, 3, 32'd8, 1, 32'h0030A423);
    send(16, 5, 5, 0, 32'd3, 1, 32'h4032D293);
`ifdef INST_ENC_RANGE_CHECK_EN
    exp_err++;
    send(3, 1, 0, 0, 32'd2048, 0, 32'd0);
`else
    send(3, 1, 0, 0, 32'd2048, 1, 32'h80000093);
`endif
    exp_err++;
    send(31, 1, 2, 3, 32'd0, 0, 32'd0);
    wait_drain();
    chk("err_cnt_dir", 32'(err_cnt), 32'(exp_err));
    chk("err_dir", 32'(err), 1);

    wr_ready = 1'b0;
    send_model(2, 4, 5, 6, 32'd0);
    held_d = wr_data;
    op_sel = 5'd7; rd_addr = 5'd9; rs1_addr = 5'd10; rs2_addr = 5'd11;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_stable", wr_data, held_d);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    send_model(7, 9, 10, 11, 32'd0);
    wait_drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bit [31:0] im;
      int k, s;
      k = $urandom_range(0, 3);
      case (k)
        0: im = $urandom;
        1: begin s = int'($urandom_range(0, 10000)) - 5000; im = s; end
        2: im = $urandom_range(0, 40);
        default: im = $urandom & 32'hFFFFF000;
      endcase
      send_model($urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), im);
      if ($urandom_range(0, 4) == 0) @(posedge clk);
      #0;
    end
    rnd_ready = 1'b0;
    @(posedge clk); #2;
    wr_ready = 1'b1;
    wait_drain();
    chk("err_cnt_rnd", 32'(err_cnt), 32'(exp_err > 255 ? 255 : exp_err));
    chk("err_rnd", 32'(err), 32'(exp_err != 0));

    wr_ready = 1'b0;
    send_model(3, 7, 1, 0, 32'd100);
    @(negedge clk); #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1 check_reset_vals("arst");
    q.delete();
    exp_addr = BASE; exp_cnt = 0; exp_err = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    wr_ready = 1'b1;

    exp_err++;
    send(31, 0, 0, 0, 32'd0, 0, 32'd0);
    send_model(6, 3, 4, 5, 32'd0);
    wait_drain();
    chk("pre_clear_err_cnt", 32'(err_cnt), 1);
    mon_en = 1'b0;
    clear = 1'b1;
    op_sel = 5'd3; rd_addr = 5'd1; rs1_addr = 5'd0; imm = 32'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("clr");
    exp_addr = BASE; exp_cnt = 0; exp_err = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    send_model(4, 8, 9, 10, 32'd0);
    wait_drain();
    chk("post_clear_cnt", 32'(word_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
